nn_input_loader: RTL and testbench

//  Input processing module (IPM) directly upstream of router_controller.
//  - Collects N_IN samples from a valid/ready stream into a two-bank frame buffer.
//  - Streams each complete frame into the state-value PRAM through the router's ipm_* handshake.
//  - Pulses nn_start once per frame so the router begins the network pass.

---
 rtl/nn_input_loader_pkg.sv | 24 ++
 rtl/ipm_frame_bank.sv | 74 +++++++
 rtl/nn_input_loader.sv | 182 ++++++++++++++++++
 tb/tb_nn_input_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_input_loader_pkg.sv
// Shared types, default widths and helpers for the input loader slice.
package nn_input_loader_pkg;

  localparam int unsigned D_LEN_DEF     = 16;
  localparam int unsigned N_IN_DEF      = 4;
  localparam int unsigned CELL_N_DEF    = 4;
  localparam int unsigned DA_AWIDTH_DEF = 8;
  localparam int unsigned OFS_WIDTH_DEF = 2;
  localparam int unsigned IN_BASE_DEF   = 0;
  localparam int unsigned FCNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_STREAM,
    ST_DONE
  } stream_state_e;

  // Sample index width; a one-sample frame still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ipm_frame_bank.sv
// Two-bank frame buffer: one write port, one registered read port, per-bank full flags.
module ipm_frame_bank
  import nn_input_loader_pkg::*;
#(
  parameter int unsigned D_LEN = D_LEN_DEF,
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned IDX_W = idx_width(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [D_LEN-1:0] wr_data,
  input  logic             wr_last,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [D_LEN-1:0] rd_data,
  input  logic             rel,
  output logic [1:0]       full,
  output logic             strm_sel
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [D_LEN-1:0] mem [2][DEPTH];
  logic             fill_sel;
  logic             fill_sel_nxt;
  logic             strm_sel_nxt;
  logic [1:0]       full_nxt;

  // Sample storage, written into the bank currently being filled.
  always_ff @(posedge clk) begin
    if (wr_en) mem[fill_sel][wr_idx] <= wr_data;
  end

  // Read register; reads as zero when the streamer is not driving the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_en ? mem[rd_bank][rd_idx] : '0;
  end

  // Full flags and bank selects after this edge; completion and release hit different banks.
  always_comb begin
    full_nxt     = full;
    fill_sel_nxt = fill_sel;
    strm_sel_nxt = strm_sel;
    if (wr_en && wr_last) begin
      full_nxt[fill_sel] = 1'b1;
      fill_sel_nxt       = ~fill_sel;
    end
    if (rel) begin
      full_nxt[strm_sel] = 1'b0;
      strm_sel_nxt       = ~strm_sel;
    end
  end

  // Bank bookkeeping; ready looks ahead so a freed bank is usable with no lost cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      fill_sel <= 1'b0;
      strm_sel <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      full     <= full_nxt;
      fill_sel <= fill_sel_nxt;
      strm_sel <= strm_sel_nxt;
      wr_ready <= ~full_nxt[fill_sel_nxt];
    end
  end

endmodule

// File: rtl/nn_input_loader.sv
// Input loader: fills frames from a sample stream and streams them into the state PRAM.
module nn_input_loader
  import nn_input_loader_pkg::*;
#(
  parameter int unsigned D_LEN     = D_LEN_DEF,
  parameter int unsigned N_IN      = N_IN_DEF,
  parameter int unsigned CELL_N    = CELL_N_DEF,
  parameter int unsigned DA_AWIDTH = DA_AWIDTH_DEF,
  parameter int unsigned OFS_WIDTH = OFS_WIDTH_DEF,
  parameter int unsigned IN_BASE   = IN_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [D_LEN-1:0]     s_data,
  output logic                 ipm_request,
  input  logic                 ipm_enable,
  output logic [D_LEN-1:0]     ipm_din,
  output logic [DA_AWIDTH-1:0] ipm_base,
  output logic [OFS_WIDTH-1:0] ipm_offset,
  output logic                 ipm_wen,
  output logic                 ipm_finish,
  output logic                 nn_start,
  output logic [FCNT_W-1:0]    frame_cnt
);

  localparam int unsigned          IDX_W    = idx_width(N_IN);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_IN - 1);
  localparam logic [OFS_WIDTH-1:0] OFS_LAST = OFS_WIDTH'(CELL_N - 1);
  localparam logic [DA_AWIDTH-1:0] ROW0     = DA_AWIDTH'(IN_BASE);

  stream_state_e        state, state_nxt;
  logic [IDX_W-1:0]     fi;
  logic [IDX_W-1:0]     idx, idx_nxt, idx_inc;
  logic [DA_AWIDTH-1:0] base_nxt, base_inc;
  logic [OFS_WIDTH-1:0] ofs_nxt, ofs_inc;
  logic                 req_nxt, fin_nxt, start_nxt;
  logic [FCNT_W-1:0]    cnt_nxt;
  logic                 s_acc, fill_last;
  logic                 rd_en, rd_bank, rel, strm_sel;
  logic [IDX_W-1:0]     rd_idx;
  logic [1:0]           full;

  // The router's own grant-cycle write is never wanted.
  assign ipm_wen   = 1'b0;
  assign s_acc     = s_valid & s_ready;
  assign fill_last = (fi == IDX_LAST);

  // Fill index within the bank being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     fi <= '0;
    else if (s_acc) fi <= fill_last ? '0 : fi + IDX_W'(1);
  end

  ipm_frame_bank #(
    .D_LEN (D_LEN),
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (s_acc),
    .wr_idx   (fi),
    .wr_data  (s_data),
    .wr_last  (fill_last),
    .wr_ready (s_ready),
    .rd_en    (rd_en),
    .rd_bank  (rd_bank),
    .rd_idx   (rd_idx),
    .rd_data  (ipm_din),
    .rel      (rel),
    .full     (full),
    .strm_sel (strm_sel)
  );

  // Stream FSM next state and next registered outputs; outputs idle at zero.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    base_nxt  = '0;
    ofs_nxt   = '0;
    req_nxt   = 1'b0;
    fin_nxt   = 1'b0;
    start_nxt = 1'b0;
    cnt_nxt   = frame_cnt;
    rd_en     = 1'b0;
    rd_bank   = strm_sel;
    rd_idx    = '0;
    rel       = 1'b0;
    idx_inc   = idx + IDX_W'(1);
    ofs_inc   = (ipm_offset == OFS_LAST) ? '0 : ipm_offset + OFS_WIDTH'(1);
    base_inc  = (ipm_offset == OFS_LAST) ? ipm_base + DA_AWIDTH'(1) : ipm_base;
    unique case (state)
      ST_IDLE: begin
        if (full[strm_sel]) begin
          state_nxt = ST_REQ;
          idx_nxt   = '0;
          base_nxt  = ROW0;
          req_nxt   = 1'b1;
          fin_nxt   = (N_IN == 1);
          rd_en     = 1'b1;
        end
      end
      ST_REQ: begin
        if (ipm_enable) begin
          start_nxt = 1'b1;
          if (N_IN == 1) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_STREAM;
            idx_nxt   = idx_inc;
            base_nxt  = base_inc;
            ofs_nxt   = ofs_inc;
            fin_nxt   = (idx_inc == IDX_LAST);
            rd_en     = 1'b1;
            rd_idx    = idx_inc;
          end
        end else begin
          req_nxt  = 1'b1;
          base_nxt = ipm_base;
          ofs_nxt  = ipm_offset;
          fin_nxt  = ipm_finish;
          rd_en    = 1'b1;
          rd_idx   = idx;
        end
      end
      ST_STREAM: begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt  = idx_inc;
          base_nxt = base_inc;
          ofs_nxt  = ofs_inc;
          fin_nxt  = (idx_inc == IDX_LAST);
          rd_en    = 1'b1;
          rd_idx   = idx_inc;
        end
      end
      ST_DONE: begin
        rel     = 1'b1;
        cnt_nxt = frame_cnt + FCNT_W'(1);
        if (full[~strm_sel]) begin
          state_nxt = ST_REQ;
          idx_nxt   = '0;
          base_nxt  = ROW0;
          req_nxt   = 1'b1;
          fin_nxt   = (N_IN == 1);
          rd_en     = 1'b1;
          rd_bank   = ~strm_sel;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      ipm_base    <= '0;
      ipm_offset  <= '0;
      ipm_request <= 1'b0;
      ipm_finish  <= 1'b0;
      nn_start    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      ipm_base    <= base_nxt;
      ipm_offset  <= ofs_nxt;
      ipm_request <= req_nxt;
      ipm_finish  <= fin_nxt;
      nn_start    <= start_nxt;
      frame_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_nn_input_loader.sv
// Bench: three loader configurations on shared stimulus, each against a frame-queue reference model.
module tb_nn_input_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned OW = 2;
  localparam int          CN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          ipm_enable;

  logic          s_ready     [3];
  logic          ipm_request [3];
  logic [DW-1:0] ipm_din     [3];
  logic [AW-1:0] ipm_base    [3];
  logic [OW-1:0] ipm_offset  [3];
  logic          ipm_wen     [3];
  logic          ipm_finish  [3];
  logic          nn_start    [3];
  logic [7:0]    frame_cnt   [3];

  always #5 clk = ~clk;

  nn_input_loader #(.D_LEN(DW), .N_IN(4), .CELL_N(CN), .DA_AWIDTH(AW), .OFS_WIDTH(OW), .IN_BASE(5)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .ipm_request(ipm_request[0]), .ipm_enable(ipm_enable), .ipm_din(ipm_din[0]),
    .ipm_base(ipm_base[0]), .ipm_offset(ipm_offset[0]), .ipm_wen(ipm_wen[0]),
    .ipm_finish(ipm_finish[0]), .nn_start(nn_start[0]), .frame_cnt(frame_cnt[0]));

  nn_input_loader #(.D_LEN(DW), .N_IN(6), .CELL_N(CN), .DA_AWIDTH(AW), .OFS_WIDTH(OW), .IN_BASE(254)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .ipm_request(ipm_request[1]), .ipm_enable(ipm_enable), .ipm_din(ipm_din[1]),
    .ipm_base(ipm_base[1]), .ipm_offset(ipm_offset[1]), .ipm_wen(ipm_wen[1]),
    .ipm_finish(ipm_finish[1]), .nn_start(nn_start[1]), .frame_cnt(frame_cnt[1]));

  nn_input_loader #(.D_LEN(DW), .N_IN(1), .CELL_N(CN), .DA_AWIDTH(AW), .OFS_WIDTH(OW), .IN_BASE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[2]), .s_data(s_data),
    .ipm_request(ipm_request[2]), .ipm_enable(ipm_enable), .ipm_din(ipm_din[2]),
    .ipm_base(ipm_base[2]), .ipm_offset(ipm_offset[2]), .ipm_wen(ipm_wen[2]),
    .ipm_finish(ipm_finish[2]), .nn_start(nn_start[2]), .frame_cnt(frame_cnt[2]));

  // Reference model: completed frames queued in order, plus the bus position of the head frame.
  // pos: -1 no frame on the bus, 0 requesting with word0, k shows word k, N_IN = frame finished.
  int nin [3] = '{4, 6, 1};
  int bas [3] = '{5, 254, 2};
  int fq   [3][$];
  int part [3][$];
  int pos  [3];
  int fcnt [3];
  bit rdy  [3];
  bit nst  [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      fq[i].delete();
      part[i].delete();
      pos[i]  = -1;
      fcnt[i] = 0;
      rdy[i]  = 1'b0;
      nst[i]  = 1'b0;
    end
  endtask

  // One clock edge of the model, using the state that held before the edge.
  task automatic model_step(input int i, input bit sv, input int sd, input bit en);
    int n, held, np;
    bit acc;
    n    = nin[i];
    held = fq[i].size() / n;
    acc  = sv && rdy[i];
    np   = pos[i];
    nst[i] = 1'b0;
    if (pos[i] < 0) begin
      if (held >= 1) np = 0;
    end else if (pos[i] == 0) begin
      if (en) begin
        np     = 1;
        nst[i] = 1'b1;
      end
    end else if (pos[i] < n) begin
      np = pos[i] + 1;
    end else begin
      for (int k = 0; k < n; k++) void'(fq[i].pop_front());
      fcnt[i] = (fcnt[i] + 1) % 256;
      np = (held >= 2) ? 0 : -1;
    end
    pos[i] = np;
    if (acc) begin
      part[i].push_back(sd);
      if (part[i].size() == n) begin
        for (int k = 0; k < n; k++) fq[i].push_back(part[i][k]);
        part[i].delete();
      end
    end
    rdy[i] = (fq[i].size() / n) < 2;
  endtask

  task automatic compare(input int i);
    int p, n, e_din, e_row, e_ofs;
    bit act;
    p = pos[i];
    n = nin[i];
    act = (p >= 0) && (p < n);
    e_din = 0;
    e_row = 0;
    e_ofs = 0;
    if (act) begin
      e_din = fq[i][p];
      e_row = (bas[i] + p / CN) % 256;
      e_ofs = p % CN;
    end
    check($sformatf("s_ready%0d", i),  32'(s_ready[i]),     32'(rdy[i]));
    check($sformatf("request%0d", i),  32'(ipm_request[i]), 32'(p == 0));
    check($sformatf("din%0d", i),      32'(ipm_din[i]),     32'(e_din));
    check($sformatf("row%0d", i),      32'(ipm_base[i]),    32'(e_row));
    check($sformatf("offset%0d", i),   32'(ipm_offset[i]),  32'(e_ofs));
    check($sformatf("finish%0d", i),   32'(ipm_finish[i]),  32'(act && (p == n - 1)));
    check($sformatf("nn_start%0d", i), 32'(nn_start[i]),    32'(nst[i]));
    check($sformatf("frame_cnt%0d", i), 32'(frame_cnt[i]),  32'(fcnt[i]));
    check($sformatf("wen%0d", i),      32'(ipm_wen[i]),     32'd0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check on the falling edge.
  task automatic tick(input bit sv, input int sd, input bit en);
    s_valid    = sv;
    s_data     = DW'(sd);
    ipm_enable = en;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, sv, sd, en);
    @(negedge clk);
    for (int i = 0; i < 3; i++) compare(i);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i),   32'(s_ready[i]),     32'd0);
      check($sformatf("rst_request%0d", i), 32'(ipm_request[i]), 32'd0);
      check($sformatf("rst_din%0d", i),     32'(ipm_din[i]),     32'd0);
      check($sformatf("rst_row%0d", i),     32'(ipm_base[i]),    32'd0);
      check($sformatf("rst_finish%0d", i),  32'(ipm_finish[i]),  32'd0);
      check($sformatf("rst_start%0d", i),   32'(nn_start[i]),    32'd0);
      check($sformatf("rst_cnt%0d", i),     32'(frame_cnt[i]),   32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    s_valid    = 1'b0;
    s_data     = '0;
    ipm_enable = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) compare(i);
    rst_n = 1'b1;
    tick(1'b0, 0, 1'b0);

    // Known frame 10,20,30,40; grant a few cycles after the request rises.
    tick(1'b1, 10, 1'b0);
    tick(1'b1, 20, 1'b0);
    tick(1'b1, 30, 1'b0);
    tick(1'b1, 40, 1'b0);
    repeat (4) tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b1);
    repeat (8) tick(1'b0, 0, 1'b0);
    check("frame_cnt_after_first", 32'(frame_cnt[0]), 32'd1);

    // Grant withheld while samples keep coming: both banks fill and the stream backs up.
    repeat (40) tick(1'b1, int'($urandom_range(0, 65535)), 1'b0);
    repeat (60) tick(1'b1, int'($urandom_range(0, 65535)), ($urandom % 3) == 0);

    // Random traffic with sporadic grants, including grants outside any request.
    repeat (1500) tick(($urandom % 4) != 0, int'($urandom_range(0, 65535)), ($urandom % 3) == 0);

    // Saturated traffic with a constant grant: fill completion and release coincide.
    repeat (300) tick(1'b1, int'($urandom_range(0, 65535)), 1'b1);

    // Reset after two samples of a fresh frame; nothing may be requested from the partial frame.
    async_reset();
    tick(1'b0, 0, 1'b0);
    tick(1'b1, int'($urandom_range(0, 65535)), 1'b0);
    tick(1'b1, int'($urandom_range(0, 65535)), 1'b0);
    async_reset();
    repeat (6) tick(1'b0, 0, 1'b1);
    repeat (400) tick(($urandom % 2) != 0, int'($urandom_range(0, 65535)), ($urandom % 2) == 0);

    // Drain.
    repeat (40) tick(1'b0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
